// File: rtl/menu_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : menu_sched_if
// Description : Bus bundle between the mouse/timing/game side and the menu
//               sequencer. master = stimulus side, slave = menu_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface menu_sched_if;
    logic        vsync_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic        game_over;
    logic [1:0]  mode;
    logic        game_start;
    logic        difficulty;
    logic [11:0] color1;
    logic [11:0] color2;
    logic [1:0]  hover;

    modport master (
        output vsync_in, xpos, ypos, mouse_left, mouse_right, game_over,
        input  mode, game_start, difficulty, color1, color2, hover
    );

    modport slave (
        input  vsync_in, xpos, ypos, mouse_left, mouse_right, game_over,
        output mode, game_start, difficulty, color1, color2, hover
    );
endinterface
`default_nettype wire

// File: rtl/menu_sched.sv
`default_nettype none
// ============================================================================
// Module      : menu_sched
// Description : Menu/game flow sequencer. Hit-tests clicks on the START,
//               DIFFICULTY and COLORS rows, applies committed clicks on frame
//               ticks and drives mode, difficulty and the colour pair.
//               Optional feature macro: MENU_PAUSE_EN (right-click pause).
// Revision    : 1.0 - initial release
// ============================================================================
module menu_sched #(
    parameter int BTN_X       = 448,
    parameter int BTN_W       = 128,
    parameter int BTN_H       = 16,
    parameter int START_Y     = 200,
    parameter int DIFF_Y      = 272,
    parameter int COLOR_Y     = 472,
    parameter int OVER_FRAMES = 120
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    menu_sched_if.slave     bus
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_armed = 3'd1;
    localparam logic [2:0]  c_st_play  = 3'd2;
    localparam logic [2:0]  c_st_over  = 3'd3;
    localparam logic [2:0]  c_st_pause = 3'd4;

    localparam logic [1:0]  c_hit_none  = 2'd0;
    localparam logic [1:0]  c_hit_start = 2'd1;
    localparam logic [1:0]  c_hit_diff  = 2'd2;
    localparam logic [1:0]  c_hit_col   = 2'd3;

    localparam logic [11:0] c_x_lo     = 12'(BTN_X);
    localparam logic [11:0] c_x_hi     = 12'(BTN_X + BTN_W);
    localparam logic [11:0] c_start_lo = 12'(START_Y);
    localparam logic [11:0] c_start_hi = 12'(START_Y + BTN_H);
    localparam logic [11:0] c_diff_lo  = 12'(DIFF_Y);
    localparam logic [11:0] c_diff_hi  = 12'(DIFF_Y + BTN_H);
    localparam logic [11:0] c_col_lo   = 12'(COLOR_Y);
    localparam logic [11:0] c_col_hi   = 12'(COLOR_Y + BTN_H);
    localparam logic [7:0]  c_over_last = 8'(OVER_FRAMES - 1);

    logic [2:0] r_state;
    logic [1:0] r_item;
    logic [1:0] r_hover;
    logic [1:0] r_pal;
    logic [7:0] r_frame_cnt;
    logic       r_vsync_d;
    logic       r_left_q;
    logic       r_left_qq;
    logic       r_pend_start;
    logic       r_pend_diff;
    logic       r_pend_col;
    logic       r_difficulty;
    logic       r_game_start;

    logic [1:0] w_hit;
    logic       w_in_x;
    logic       w_tick;
    logic       w_press;
    logic       w_release;

    // Combinational hit-test of the current pointer position
    always_comb begin
        w_in_x = (bus.xpos >= c_x_lo) && (bus.xpos < c_x_hi);
        w_hit  = c_hit_none;
        if (w_in_x && bus.ypos >= c_start_lo && bus.ypos < c_start_hi)
            w_hit = c_hit_start;
        else if (w_in_x && bus.ypos >= c_diff_lo && bus.ypos < c_diff_hi)
            w_hit = c_hit_diff;
        else if (w_in_x && bus.ypos >= c_col_lo && bus.ypos < c_col_hi)
            w_hit = c_hit_col;
    end

    // Left-button edges are taken from a delayed pair so they line up with
    // the registered hover value of the same sample.
    assign w_tick    = bus.vsync_in & ~r_vsync_d;
    assign w_press   = r_left_q & ~r_left_qq;
    assign w_release = ~r_left_q & r_left_qq;

    // Edge-detect history and registered hover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_left_q  <= 1'b0;
            r_left_qq <= 1'b0;
            r_hover   <= c_hit_none;
        end else begin
            r_vsync_d <= bus.vsync_in;
            r_left_q  <= bus.mouse_left;
            r_left_qq <= r_left_q;
            r_hover   <= w_hit;
        end
    end

`ifdef MENU_PAUSE_EN
    logic r_right_q;
    logic r_right_qq;
    logic w_rpress;

    assign w_rpress = r_right_q & ~r_right_qq;

    // Right-button edge history for pause toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_right_q  <= 1'b0;
            r_right_qq <= 1'b0;
        end else begin
            r_right_q  <= bus.mouse_right;
            r_right_qq <= r_right_q;
        end
    end
`else
    logic w_unused_right;
    assign w_unused_right = bus.mouse_right;
`endif

    // Menu sequencer: click arming/commit, frame-tick application, game flow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_item       <= c_hit_none;
            r_pal        <= 2'd0;
            r_frame_cnt  <= 8'd0;
            r_pend_start <= 1'b0;
            r_pend_diff  <= 1'b0;
            r_pend_col   <= 1'b0;
            r_difficulty <= 1'b0;
            r_game_start <= 1'b0;
        end else begin
            r_game_start <= 1'b0;
            case (r_state)
                c_st_idle, c_st_armed: begin
                    // Tick consumes flags that were pending before this cycle;
                    // a commit in the same cycle re-arms a flag afterwards.
                    if (w_tick) begin
                        if (r_pend_diff)
                            r_difficulty <= ~r_difficulty;
                        if (r_pend_col)
                            r_pal <= r_pal + 2'd1;
                        r_pend_start <= 1'b0;
                        r_pend_diff  <= 1'b0;
                        r_pend_col   <= 1'b0;
                    end
                    if (w_tick && r_pend_start) begin
                        r_state      <= c_st_play;
                        r_game_start <= 1'b1;
                    end else if (r_state == c_st_idle) begin
                        if (w_press && r_hover != c_hit_none) begin
                            r_state <= c_st_armed;
                            r_item  <= r_hover;
                        end
                    end else if (w_release) begin
                        r_state <= c_st_idle;
                        if (r_hover == r_item) begin
                            case (r_item)
                                c_hit_start: r_pend_start <= 1'b1;
                                c_hit_diff:  r_pend_diff  <= 1'b1;
                                c_hit_col:   r_pend_col   <= 1'b1;
                                default:     ;
                            endcase
                        end
                    end
                end
                c_st_play: begin
                    r_pend_start <= 1'b0;
                    r_pend_diff  <= 1'b0;
                    r_pend_col   <= 1'b0;
                    if (bus.game_over) begin
                        r_state     <= c_st_over;
                        r_frame_cnt <= 8'd0;
                    end
`ifdef MENU_PAUSE_EN
                    else if (w_rpress)
                        r_state <= c_st_pause;
`endif
                end
                c_st_over: begin
                    if (w_tick) begin
                        if (r_frame_cnt == c_over_last) begin
                            r_state     <= c_st_idle;
                            r_frame_cnt <= 8'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
`ifdef MENU_PAUSE_EN
                c_st_pause: begin
                    if (bus.game_over) begin
                        r_state     <= c_st_over;
                        r_frame_cnt <= 8'd0;
                    end else if (w_rpress) begin
                        r_state <= c_st_play;
                    end
                end
`endif
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Output decode: mode from state, colour pair from palette index
    always_comb begin
        case (r_state)
            c_st_play:  bus.mode = 2'd1;
            c_st_over:  bus.mode = 2'd2;
            c_st_pause: bus.mode = 2'd3;
            default:    bus.mode = 2'd0;
        endcase
        case (r_pal)
            2'd0:    begin bus.color1 = 12'hFFF; bus.color2 = 12'h000; end
            2'd1:    begin bus.color1 = 12'h0F0; bus.color2 = 12'h000; end
            2'd2:    begin bus.color1 = 12'hFF0; bus.color2 = 12'h00F; end
            default: begin bus.color1 = 12'h000; bus.color2 = 12'hFFF; end
        endcase
    end

    assign bus.game_start = r_game_start;
    assign bus.difficulty = r_difficulty;
    assign bus.hover      = r_hover;

endmodule
`default_nettype wire

// File: tb/tb_menu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_sched
// Description : Directed self-checking bench for menu_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_sched;

`ifdef MENU_PAUSE_EN
    localparam logic [1:0] c_mode_after_rclick = 2'd3;
`else
    localparam logic [1:0] c_mode_after_rclick = 2'd1;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   pulses;
    int   rpulses;

    menu_sched_if bus ();

    menu_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic move(input int x, input int y);
        @(negedge clk);
        bus.xpos = 12'(x);
        bus.ypos = 12'(y);
        wait_cycles(3);
    endtask

    task automatic click();
        @(negedge clk) bus.mouse_left = 1'b1;
        wait_cycles(3);
        @(negedge clk) bus.mouse_left = 1'b0;
        wait_cycles(3);
    endtask

    // Right click; counts game_start pulses seen meanwhile
    task automatic rclick(output int gs);
        gs = 0;
        @(negedge clk) bus.mouse_right = 1'b1;
        repeat (3) begin @(posedge clk); #1; gs += int'(bus.game_start); end
        @(negedge clk) bus.mouse_right = 1'b0;
        repeat (3) begin @(posedge clk); #1; gs += int'(bus.game_start); end
    endtask

    // One frame tick; returns number of cycles game_start was high
    task automatic frame_tick(output int gs);
        gs = 0;
        @(negedge clk) bus.vsync_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; gs += int'(bus.game_start); end
        @(negedge clk) bus.vsync_in = 1'b0;
        repeat (2) begin @(posedge clk); #1; gs += int'(bus.game_start); end
    endtask

    task automatic pulse_game_over();
        @(negedge clk) bus.game_over = 1'b1;
        @(negedge clk) bus.game_over = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.vsync_in    = 1'b0;
        bus.xpos        = 12'd0;
        bus.ypos        = 12'd0;
        bus.mouse_left  = 1'b0;
        bus.mouse_right = 1'b0;
        bus.game_over   = 1'b0;
        wait_cycles(3);
        @(negedge clk) rst_n = 1'b1;
        wait_cycles(1);

        // Reset state
        check("rst_mode",  32'(bus.mode),       32'd0);
        check("rst_diff",  32'(bus.difficulty), 32'd0);
        check("rst_c1",    32'(bus.color1),     32'hFFF);
        check("rst_c2",    32'(bus.color2),     32'h000);
        check("rst_hover", 32'(bus.hover),      32'd0);
        check("rst_gs",    32'(bus.game_start), 32'd0);

        // Difficulty toggles only at the tick
        move(460, 280);
        check("hover_diff", 32'(bus.hover), 32'd2);
        click();
        check("diff_pre_tick", 32'(bus.difficulty), 32'd0);
        frame_tick(pulses);
        check("diff_tick1", 32'(bus.difficulty), 32'd1);
        click();
        frame_tick(pulses);
        check("diff_tick2", 32'(bus.difficulty), 32'd0);
        // Two commits in one frame apply once
        click();
        click();
        frame_tick(pulses);
        check("diff_double", 32'(bus.difficulty), 32'd1);
        // Move off and back before release still commits
        @(negedge clk) bus.mouse_left = 1'b1;
        wait_cycles(3);
        move(10, 10);
        check("hover_none", 32'(bus.hover), 32'd0);
        move(460, 280);
        @(negedge clk) bus.mouse_left = 1'b0;
        wait_cycles(3);
        frame_tick(pulses);
        check("diff_offback", 32'(bus.difficulty), 32'd0);

        // Right edge boundary: x=576 is outside the button
        move(576, 280);
        check("hover_xedge", 32'(bus.hover), 32'd0);
        move(575, 487);
        check("hover_col_edge", 32'(bus.hover), 32'd3);

        // Palette walk
        move(460, 480);
        check("hover_col", 32'(bus.hover), 32'd3);
        click(); frame_tick(pulses);
        check("pal1_c1", 32'(bus.color1), 32'h0F0);
        check("pal1_c2", 32'(bus.color2), 32'h000);
        click(); frame_tick(pulses);
        check("pal2_c1", 32'(bus.color1), 32'hFF0);
        check("pal2_c2", 32'(bus.color2), 32'h00F);
        click(); frame_tick(pulses);
        check("pal3_c1", 32'(bus.color1), 32'h000);
        check("pal3_c2", 32'(bus.color2), 32'hFFF);
        click(); frame_tick(pulses);
        check("pal0_c1", 32'(bus.color1), 32'hFFF);
        check("pal0_c2", 32'(bus.color2), 32'h000);

        // Click cancel on START
        move(460, 205);
        check("hover_start", 32'(bus.hover), 32'd1);
        @(negedge clk) bus.mouse_left = 1'b1;
        wait_cycles(3);
        move(10, 10);
        @(negedge clk) bus.mouse_left = 1'b0;
        wait_cycles(3);
        frame_tick(pulses);
        check("cancel_mode", 32'(bus.mode), 32'd0);
        check("cancel_gs",   32'(pulses),   32'd0);

        // game_over outside PLAY is ignored
        pulse_game_over();
        check("go_idle_mode", 32'(bus.mode), 32'd0);

        // START commit
        move(460, 205);
        click();
        check("start_pre_tick", 32'(bus.mode), 32'd0);
        frame_tick(pulses);
        check("start_gs",   32'(pulses),   32'd1);
        check("start_mode", 32'(bus.mode), 32'd1);

        // Clicks during PLAY have no effect
        move(460, 280);
        click();
        frame_tick(pulses);
        check("play_diff", 32'(bus.difficulty), 32'd0);
        check("play_mode", 32'(bus.mode),       32'd1);

        // Game over and OVER countdown
        pulse_game_over();
        check("over_mode", 32'(bus.mode), 32'd2);
        move(460, 480);
        for (int i = 0; i < 119; i++) begin
            if (i == 50) click();
            frame_tick(pulses);
        end
        check("over_119", 32'(bus.mode), 32'd2);
        frame_tick(pulses);
        check("over_120", 32'(bus.mode), 32'd0);
        frame_tick(pulses);
        check("over_col",  32'(bus.color1),     32'hFFF);
        check("over_diff", 32'(bus.difficulty), 32'd0);

        // Back to PLAY, then pause behaviour
        move(460, 205);
        click();
        frame_tick(pulses);
        check("replay_mode", 32'(bus.mode), 32'd1);
        rclick(rpulses);
        check("rclick1_mode", 32'(bus.mode), 32'(c_mode_after_rclick));
        rclick(pulses);
        rpulses += pulses;
        check("rclick2_mode", 32'(bus.mode), 32'd1);
        check("rclick_gs",    32'(rpulses),  32'd0);
`ifdef MENU_PAUSE_EN
        rclick(pulses);
        pulse_game_over();
        check("pause_go", 32'(bus.mode), 32'd2);
`endif

        // Asynchronous reset mid-operation
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_mode",  32'(bus.mode),  32'd0);
        check("mid_rst_hover", 32'(bus.hover), 32'd0);
        wait_cycles(2);
        @(negedge clk) rst_n = 1'b1;
        wait_cycles(1);
        check("post_rst_c1", 32'(bus.color1), 32'hFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
